// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter
// Shares one single-ported memory between instruction fetch (IF) and load/store (DM).
// Data requests win by default. IF is forced through after STREAK_MAX consecutive DM
// grants made while IF was waiting. Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   if_req_*         fetch request (valid/ready/addr)
//   if_rsp_*         fetch response (one-cycle valid pulse, registered data)
//   dm_req_*         data request (valid/ready/addr/we/wdata/wmask)
//   dm_rsp_*         data response (read data or write ack, one-cycle pulse)
//   mem_req_*        request to memory, driven combinationally from the granted requester
//   mem_rsp_*        memory response, one per accepted request
module ama_riscv_mem_arbiter #(
  parameter int unsigned AW         = 14,
  parameter int unsigned DW         = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch requester
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  // data requester
  input  logic            dm_req_valid,
  output logic            dm_req_ready,
  input  logic [AW-1:0]   dm_req_addr,
  input  logic            dm_req_we,
  input  logic [DW-1:0]   dm_req_wdata,
  input  logic [DW/8-1:0] dm_req_wmask,
  output logic            dm_rsp_valid,
  output logic [DW-1:0]   dm_rsp_data,
  // memory port
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_we,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] StreakMax = SW'(STREAK_MAX);

  typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

  state_e        state_q;
  logic          owner_dm_q;  // 1: DM owns the current transaction, 0: IF
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  logic grant_valid;
  logic grant_dm;
  logic handshake;

  // Arbitrate only in IDLE; HOLD replays the locked owner so the request stays stable.
  always_comb begin
    grant_valid = 1'b0;
    grant_dm    = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_valid = if_req_valid | dm_req_valid;
        grant_dm    = dm_req_valid & ~(if_req_valid & (streak_q >= StreakMax));
      end
      StHold: begin
        grant_valid = 1'b1;
        grant_dm    = owner_dm_q;
      end
      default: ;
    endcase
  end

  assign mem_req_valid = grant_valid;
  assign mem_req_addr  = grant_dm ? dm_req_addr : if_req_addr;
  assign mem_req_we    = grant_dm & dm_req_we;
  assign mem_req_wdata = grant_dm ? dm_req_wdata : '0;
  assign mem_req_wmask = grant_dm ? dm_req_wmask : '0;

  assign if_req_ready  = grant_valid & ~grant_dm & mem_req_ready;
  assign dm_req_ready  = grant_valid &  grant_dm & mem_req_ready;
  assign handshake     = grant_valid & mem_req_ready;

  // Streak counts DM wins only while IF is actually waiting.
  always_comb begin
    streak_d = '0;
    if (grant_dm && if_req_valid) begin
      streak_d = (streak_q >= StreakMax) ? StreakMax : streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_dm_q   <= 1'b0;
      streak_q     <= '0;
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      dm_rsp_data  <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle, StHold: begin
          if (handshake) begin
            state_q    <= StWait;
            owner_dm_q <= grant_dm;
            streak_q   <= streak_d;
          end else if (grant_valid) begin
            state_q    <= StHold;
            owner_dm_q <= grant_dm;
          end
        end
        StWait: begin
          // Responses outside WAIT are never looked at.
          if (mem_rsp_valid) begin
            state_q <= StIdle;
            if (owner_dm_q) begin
              dm_rsp_valid <= 1'b1;
              dm_rsp_data  <= mem_rsp_data;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Self-checking bench for ama_riscv_mem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_ama_riscv_mem_arbiter;

  localparam int unsigned AW         = 14;
  localparam int unsigned DW         = 32;
  localparam int unsigned MW         = DW / 8;
  localparam int unsigned STREAK_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid, dm_req_ready;
  logic [AW-1:0] dm_req_addr;
  logic          dm_req_we;
  logic [DW-1:0] dm_req_wdata;
  logic [MW-1:0] dm_req_wmask;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_data;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_we;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  ama_riscv_mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid),
    .dm_req_ready(dm_req_ready),
    .dm_req_addr(dm_req_addr),
    .dm_req_we(dm_req_we),
    .dm_req_wdata(dm_req_wdata),
    .dm_req_wmask(dm_req_wmask),
    .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: is a transaction in flight, is a grant locked, who owns it, streak.
  bit            m_busy, m_locked, m_owner_dm;
  int            m_streak;
  bit            e_if_rv, e_dm_rv;
  logic [DW-1:0] e_if_rd = '0;
  logic [DW-1:0] e_dm_rd = '0;
  bit            g_valid, g_dm;

  // Environment state
  bit            if_acc, dm_acc, mem_hs;
  int            rsp_wait = 0;
  int            lat_min = 1, lat_max = 1;
  int            p_if = 0, p_dm = 0, p_rdy = 100;
  bit            fixed_en = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  int            stray_cnt = 0, viol_cnt = 0;
  bit            grant_log[$];
  bit            exp_order[10];

  task automatic sample();
    logic [AW-1:0] e_addr;
    @(negedge clk);
    if (m_busy) begin
      g_valid = 1'b0;
      g_dm    = 1'b0;
    end else if (m_locked) begin
      g_valid = 1'b1;
      g_dm    = m_owner_dm;
    end else begin
      g_valid = if_req_valid || dm_req_valid;
      g_dm    = dm_req_valid && !(if_req_valid && m_streak >= STREAK_MAX);
    end
    if (!m_busy && mem_rsp_valid) begin
      stray_cnt++;
      $display("[TB] note: mem_rsp_valid outside WAIT ignored at %0t", $time);
    end
    if (m_locked && !(m_owner_dm ? dm_req_valid : if_req_valid)) viol_cnt++;

    check_eq("mem_req_valid", 64'(mem_req_valid), 64'(g_valid));
    if (g_valid) begin
      e_addr = g_dm ? dm_req_addr : if_req_addr;
      check_eq("mem_req_addr", 64'(mem_req_addr), 64'(e_addr));
      check_eq("mem_req_we", 64'(mem_req_we), 64'(g_dm && dm_req_we));
      check_eq("mem_req_wdata", 64'(mem_req_wdata), 64'(g_dm ? dm_req_wdata : '0));
      check_eq("mem_req_wmask", 64'(mem_req_wmask), 64'(g_dm ? dm_req_wmask : '0));
    end
    check_eq("if_req_ready", 64'(if_req_ready), 64'(g_valid && !g_dm && mem_req_ready));
    check_eq("dm_req_ready", 64'(dm_req_ready), 64'(g_valid && g_dm && mem_req_ready));
    check_eq("if_rsp_valid", 64'(if_rsp_valid), 64'(e_if_rv));
    check_eq("dm_rsp_valid", 64'(dm_rsp_valid), 64'(e_dm_rv));
    check_eq("if_rsp_data", 64'(if_rsp_data), 64'(e_if_rd));
    check_eq("dm_rsp_data", 64'(dm_rsp_data), 64'(e_dm_rd));

    if_acc = if_req_valid && if_req_ready;
    dm_acc = dm_req_valid && dm_req_ready;
    mem_hs = mem_req_valid && mem_req_ready && !rst;
    if (mem_hs) grant_log.push_back(dm_req_ready);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    // Model update uses the inputs that were present at the edge.
    if (rst) begin
      m_busy = 0; m_locked = 0; m_owner_dm = 0; m_streak = 0;
      e_if_rv = 0; e_dm_rv = 0; e_if_rd = '0; e_dm_rd = '0;
    end else begin
      e_if_rv = 0;
      e_dm_rv = 0;
      if (m_busy) begin
        if (mem_rsp_valid) begin
          m_busy = 0;
          if (m_owner_dm) begin
            e_dm_rv = 1; e_dm_rd = mem_rsp_data;
          end else begin
            e_if_rv = 1; e_if_rd = mem_rsp_data;
          end
        end
      end else if (g_valid && mem_req_ready) begin
        m_busy = 1; m_locked = 0; m_owner_dm = g_dm;
        if (!g_dm || !if_req_valid) m_streak = 0;
        else if (m_streak < STREAK_MAX) m_streak++;
      end else if (g_valid) begin
        m_locked = 1; m_owner_dm = g_dm;
      end
    end

    // Memory stub: one response L cycles after each accepted request.
    if (mem_hs) rsp_wait = $urandom_range(lat_max, lat_min);
    mem_rsp_data = $urandom();
    if (rsp_wait > 0) begin
      rsp_wait--;
      mem_rsp_valid = (rsp_wait == 0);
      if (fixed_en) mem_rsp_data = fixed_rdata;
    end else begin
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = ($urandom_range(99) < p_rdy);

    // Requesters hold valid and payload until accepted.
    if (if_acc) if_req_valid = 1'b0;
    if (!if_req_valid && $urandom_range(99) < p_if) begin
      if_req_valid = 1'b1;
      if_req_addr  = AW'($urandom());
    end
    if (dm_acc) dm_req_valid = 1'b0;
    if (!dm_req_valid && $urandom_range(99) < p_dm) begin
      dm_req_valid = 1'b1;
      dm_req_addr  = AW'($urandom());
      dm_req_we    = 1'($urandom_range(1));
      dm_req_wdata = $urandom();
      dm_req_wmask = MW'($urandom());
    end
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_req_addr = '0;
    dm_req_valid = 0; dm_req_addr = '0; dm_req_we = 0; dm_req_wdata = '0; dm_req_wmask = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    sample();
    check_eq("rst_if_ready", 64'(if_req_ready), 64'(0));
    check_eq("rst_dm_ready", 64'(dm_req_ready), 64'(0));
    check_eq("rst_mem_valid", 64'(mem_req_valid), 64'(0));
    check_eq("rst_rsp_data", 64'({if_rsp_data, dm_rsp_data}), 64'(0));
    advance();

    // Single IF read, L=1
    fixed_en = 1; fixed_rdata = 32'hDEADBEEF;
    if_req_valid = 1; if_req_addr = 14'h0100; mem_req_ready = 1;
    sample();
    check_eq("if_read_hs", 64'(if_req_ready && mem_req_valid), 64'(1));
    check_eq("if_read_addr", 64'(mem_req_addr), 64'(14'h0100));
    advance();
    cycle();
    sample();
    check_eq("if_read_rsp_valid", 64'(if_rsp_valid), 64'(1));
    check_eq("if_read_rsp_data", 64'(if_rsp_data), 64'(32'hDEADBEEF));
    check_eq("if_read_no_dm_rsp", 64'(dm_rsp_valid), 64'(0));
    advance();
    sample();
    check_eq("if_read_pulse_end", 64'(if_rsp_valid), 64'(0));
    advance();
    fixed_en = 0;

    // DM write, then IF request on the same port
    dm_req_valid = 1; dm_req_addr = 14'h0abc; dm_req_we = 1;
    dm_req_wdata = 32'h1234_5678; dm_req_wmask = 4'b0011;
    sample();
    check_eq("dm_wr_we", 64'(mem_req_we), 64'(1));
    check_eq("dm_wr_mask", 64'(mem_req_wmask), 64'(4'b0011));
    check_eq("dm_wr_data", 64'(mem_req_wdata), 64'(32'h1234_5678));
    advance();
    cycle();
    sample();
    check_eq("dm_wr_ack", 64'(dm_rsp_valid), 64'(1));
    check_eq("dm_wr_no_if_rsp", 64'(if_rsp_valid), 64'(0));
    advance();
    if_req_valid = 1; if_req_addr = 14'h0200;
    sample();
    check_eq("if_we_zero", 64'(mem_req_we), 64'(0));
    check_eq("if_mask_zero", 64'(mem_req_wmask), 64'(0));
    advance();
    repeat (3) cycle();

    // Backpressure: IF locked in HOLD while DM asserts valid
    p_rdy = 0; mem_req_ready = 0;
    if_req_valid = 1; if_req_addr = 14'h0321;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq($sformatf("bp_addr_%0d", i), 64'(mem_req_addr), 64'(14'h0321));
      check_eq($sformatf("bp_dm_ready_%0d", i), 64'(dm_req_ready), 64'(0));
      check_eq($sformatf("bp_mem_valid_%0d", i), 64'(mem_req_valid), 64'(1));
      advance();
      if (i == 0) begin
        dm_req_valid = 1; dm_req_addr = 14'h0777; dm_req_we = 0;
      end
    end
    p_rdy = 100; mem_req_ready = 1;
    grant_log.delete();
    sample();
    check_eq("bp_if_hs", 64'(if_req_ready), 64'(1));
    check_eq("bp_dm_not_ready", 64'(dm_req_ready), 64'(0));
    advance();
    check_eq("bp_owner_if", 64'(grant_log.size() == 1 && grant_log[0] == 1'b0), 64'(1));
    repeat (6) cycle();

    // Continuous contention from a freshly reset streak
    rst = 1; cycle(); rst = 0;
    p_if = 100; p_dm = 100; lat_min = 1; lat_max = 1;
    cycle();
    grant_log.delete();
    for (int n = 0; n < 200 && grant_log.size() < 10; n++) cycle();
    check_eq("contention_count", 64'(grant_log.size() >= 10), 64'(1));
    for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
      check_eq($sformatf("contention_grant_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    end
    p_if = 0; p_dm = 0;
    repeat (10) cycle();

    // Reset in WAIT, stale response arrives afterwards
    lat_min = 3; lat_max = 3;
    dm_req_valid = 1; dm_req_addr = 14'h0055; dm_req_we = 0;
    sample();
    check_eq("rstw_dm_hs", 64'(dm_req_ready), 64'(1));
    advance();
    rst = 1; cycle(); rst = 0;
    cycle();
    sample();
    check_eq("rstw_stale_seen", 64'(mem_rsp_valid), 64'(1));
    advance();
    sample();
    check_eq("rstw_no_if_rsp", 64'(if_rsp_valid), 64'(0));
    check_eq("rstw_no_dm_rsp", 64'(dm_rsp_valid), 64'(0));
    advance();
    lat_min = 1; lat_max = 1;
    dm_req_valid = 1; dm_req_addr = 14'h0066; dm_req_we = 0;
    sample();
    check_eq("rstw_next_hs", 64'(dm_req_ready), 64'(1));
    advance();
    cycle();
    sample();
    check_eq("rstw_next_rsp", 64'(dm_rsp_valid), 64'(1));
    advance();

    // Stray response in IDLE
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    cycle();
    sample();
    check_eq("stray_no_if_rsp", 64'(if_rsp_valid), 64'(0));
    check_eq("stray_no_dm_rsp", 64'(dm_rsp_valid), 64'(0));
    advance();
    check_eq("stray_flagged", 64'(stray_cnt), 64'(2));

    // Random traffic with random backpressure and latency
    p_if = 50; p_dm = 60; p_rdy = 70; lat_min = 1; lat_max = 3;
    repeat (3000) cycle();
    p_if = 0; p_dm = 0; p_rdy = 100;
    repeat (20) cycle();
    check_eq("protocol_violations", 64'(viol_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
